// File: rtl/div_32.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Shares the ce_i/ready_o stall handshake with the multiplier.
//
// state | meaning
// IDLE  | waiting for ce_i; operands are latched on the first enabled edge
// BUSY  | one restoring step per enabled edge, 32 steps total
// DONE  | result_o valid; held until ce_i drops
module div_32 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] result_o,
    output logic        ready_o,
    output logic [1:0]  status_o
);

    localparam int GPR_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    state_t                 state_q, state_d;
    logic [4:0]             cnt_q;
    logic [GPR_WIDTH-1:0]   dvd_q;
    logic [GPR_WIDTH-1:0]   dvs_q;
    logic [GPR_WIDTH:0]     rem_q;
    logic [GPR_WIDTH-1:0]   quo_q;
    logic                   op_rem_q;
    logic                   neg_quo_q;
    logic                   neg_rem_q;
    logic [GPR_WIDTH-1:0]   result_q;

    // operand decode used only on the start edge
    logic                   op_signed;
    logic                   op_rem;
    logic [GPR_WIDTH-1:0]   dvd_abs;
    logic [GPR_WIDTH-1:0]   dvs_abs;
    logic                   div_zero;
    logic                   ovf;
    logic                   fast_path;
    logic [GPR_WIDTH-1:0]   fast_res;

    assign op_signed = ~op_i[0];
    assign op_rem    = op_i[1];
    assign dvd_abs   = (op_signed && rs1_i[31]) ? -rs1_i : rs1_i;
    assign dvs_abs   = (op_signed && rs2_i[31]) ? -rs2_i : rs2_i;
    assign div_zero  = (rs2_i == '0);
    assign ovf       = op_signed && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
    assign fast_path = div_zero || ovf;
    assign fast_res  = div_zero ? (op_rem ? rs1_i : 32'hFFFF_FFFF)
                                : (op_rem ? 32'h0 : 32'h8000_0000);

    // one restoring step: the partial remainder never exceeds the divisor,
    // so a 34-bit trial difference always carries a valid sign bit
    logic [GPR_WIDTH+1:0]   diff;
    logic                   take;
    logic [GPR_WIDTH:0]     rem_step;
    logic [GPR_WIDTH-1:0]   quo_step;
    logic [GPR_WIDTH-1:0]   quo_final;
    logic [GPR_WIDTH-1:0]   rem_final;
    logic                   last_step;

    assign diff      = {1'b0, rem_q, dvd_q[GPR_WIDTH-1]} - {2'b00, dvs_q};
    assign take      = ~diff[GPR_WIDTH+1];
    assign rem_step  = take ? diff[GPR_WIDTH:0] : {rem_q[GPR_WIDTH-1:0], dvd_q[GPR_WIDTH-1]};
    assign quo_step  = {quo_q[GPR_WIDTH-2:0], take};
    assign quo_final = neg_quo_q ? -quo_step : quo_step;
    assign rem_final = neg_rem_q ? -rem_step[GPR_WIDTH-1:0] : rem_step[GPR_WIDTH-1:0];
    assign last_step = (cnt_q == 5'd31);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (ce_i) begin
                    state_d = fast_path ? ST_DONE : ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!ce_i) begin
                    state_d = ST_IDLE;
                end else if (last_step) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = ce_i ? ST_DONE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            op_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ce_i) begin
                        cnt_q     <= '0;
                        dvd_q     <= dvd_abs;
                        dvs_q     <= dvs_abs;
                        rem_q     <= '0;
                        quo_q     <= '0;
                        op_rem_q  <= op_rem;
                        neg_quo_q <= op_signed && (rs1_i[31] ^ rs2_i[31]);
                        neg_rem_q <= op_signed && rs1_i[31];
                        if (fast_path) begin
                            result_q <= fast_res;
                        end
                    end
                end
                ST_BUSY: begin
                    if (ce_i) begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        dvd_q <= {dvd_q[GPR_WIDTH-2:0], 1'b0};
                        cnt_q <= cnt_q + 5'd1;
                        if (last_step) begin
                            result_q <= op_rem_q ? rem_final : quo_final;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign status_o = state_q;
    assign ready_o  = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !ce_i);

endmodule

// File: tb/tb_div_32.sv
// Scoreboard bench for div_32: a behavioural reference pushes expected
// results at issue time; they are popped when ready_o rises.
module tb_div_32;

    logic        clk_i;
    logic        rst_i;
    logic        ce_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic [1:0]  status_o;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp;

    div_32 dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ce_i     (ce_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .result_o (result_o),
        .ready_o  (ready_o),
        .status_o (status_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'b00:   return $signed(a) / $signed(b);
            2'b01:   return a / b;
            2'b10:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic int latency_of(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // waits for ready_o, compares against the scoreboard, checks hold and release
    task automatic wait_done(input int exp_lat, input bit wiggle);
        int lat = 0;
        logic [31:0] exp;
        do begin
            @(posedge clk_i); #1;
            lat++;
            if (wiggle && lat == 5) begin
                rs1_i = $urandom;
                rs2_i = $urandom;
                op_i  = 2'($urandom);
            end
        end while (!ready_o && lat < 40);
        check("latency", lat, exp_lat);
        check("status_done", status_o, 2'b10);
        exp = sb_q.pop_front();
        check("result", result_o, exp);
        last_exp = exp;
        repeat (2) @(posedge clk_i);
        #1;
        check("hold_status", status_o, 2'b10);
        check("hold_result", result_o, exp);
        @(negedge clk_i);
        ce_i  = 1'b0;
        rs1_i = $urandom;
        @(posedge clk_i); #1;
        check("release_idle", status_o, 2'b00);
        check("release_ready", ready_o, 1'b1);
        check("release_result", result_o, exp);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit wiggle);
        @(negedge clk_i);
        op_i  = op;
        rs1_i = a;
        rs2_i = b;
        ce_i  = 1'b1;
        sb_q.push_back(model(op, a, b));
        #1;
        check("ready_fall", ready_o, 1'b0);
        wait_done(latency_of(op, a, b), wiggle);
    endtask

    initial begin
        rst_i = 1'b0;
        ce_i  = 1'b0;
        op_i  = 2'b00;
        rs1_i = '0;
        rs2_i = '0;
        last_exp = '0;
        #3;
        check("rst_result", result_o, 32'h0);
        check("rst_status", status_o, 2'b00);
        check("rst_ready_ce0", ready_o, 1'b1);
        ce_i = 1'b1;
        #1;
        check("rst_ready_ce1", ready_o, 1'b0);
        ce_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;

        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_op(2'(k), 32'h1234_5678, 32'h0, 1'b0);
        end
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 1'b0);

        // abort mid-operation leaves result_o untouched
        @(negedge clk_i);
        op_i  = 2'b01;
        rs1_i = 32'd100;
        rs2_i = 32'd7;
        ce_i  = 1'b1;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        check("abort_busy", status_o, 2'b01);
        ce_i = 1'b0;
        @(posedge clk_i); #1;
        check("abort_idle", status_o, 2'b00);
        check("abort_result", result_o, last_exp);

        run_op(2'b01, 32'd100, 32'd7, 1'b0);
        run_op(2'b01, 32'd100, 32'd7, 1'b1);
        run_op(2'b10, 32'hFFFF_FF00, 32'd37, 1'b1);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] b;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            run_op(2'($urandom_range(0, 3)), $urandom, b, 1'b0);
        end

        // asynchronous reset in the middle of BUSY
        @(negedge clk_i);
        op_i  = 2'b00;
        rs1_i = 32'd999;
        rs2_i = 32'd3;
        ce_i  = 1'b1;
        repeat (6) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("mid_rst_status", status_o, 2'b00);
        check("mid_rst_result", result_o, 32'h0);
        check("mid_rst_ready_ce1", ready_o, 1'b0);
        ce_i = 1'b0;
        #1;
        check("mid_rst_ready_ce0", ready_o, 1'b1);

        // ce_i high at release starts on the first edge after it
        op_i  = 2'b01;
        rs1_i = 32'd1000;
        rs2_i = 32'd10;
        ce_i  = 1'b1;
        sb_q.push_back(model(2'b01, 32'd1000, 32'd10));
        @(negedge clk_i);
        rst_i = 1'b1;
        wait_done(33, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_32.md
# div_32

Multi-cycle 32-bit integer divider implementing RV32M DIV, DIVU, REM and REMU in the execute stage, alongside the multiplier. It uses the same ce_i/ready_o handshake as the multiplier, so the pipeline stalls on ready_o low. The core is a radix-2 restoring divider: one quotient bit per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.

## Interface
- Parameters: none. All datapath widths are `GPR_WIDTH` (32).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- ce_i  in  1  chip enable. High requests and holds an operation; low aborts or releases.
- op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Sampled at start only.
- rs1_i  in  32  dividend. Sampled at start only.
- rs2_i  in  32  divisor. Sampled at start only.
- result_o  out  32  quotient or remainder, per the latched op. Registered.
- ready_o  out  1  high when idle with ce_i low, or when the result is valid. Combinational from state and ce_i.
- status_o  out  2  state encoding: 00 IDLE, 01 BUSY, 10 DONE.

## Operation
- **Registered state:** state, 5-bit iteration count cnt, |dividend|, |divisor|, 33-bit partial remainder, 32-bit quotient, latched op, sign flags for quotient and remainder, result register.
- **IDLE, ce_i = 1:** latch op_i, rs1_i, rs2_i and compute magnitudes. Signed ops negate negative operands; unsigned ops take them as-is.
  - Divisor = 0 → DONE. Quotient result = 0xFFFFFFFF. Remainder result = rs1_i unchanged.
  - DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF → DONE. DIV result = 0x80000000. REM result = 0.
  - Otherwise → BUSY, with cnt = 0, partial remainder = 0, quotient = 0.
- **BUSY, each edge with ce_i = 1:** run one restoring step.
  - Shift the partial remainder left one bit, bringing in the next dividend bit (MSB first).
  - Trial-subtract |divisor|. If the difference is non-negative, keep it and shift 1 into the quotient; otherwise restore and shift 0.
  - cnt increments each step.
- **Last step (cnt = 31):** state → DONE, and result_o is loaded from the final values.
  - Quotient is negated when the operation is signed and the operand signs differ.
  - Remainder is negated when the operation is signed and the dividend is negative.
- **DONE:** result_o holds while ce_i = 1.
  - ce_i = 0 → IDLE on the next edge. result_o keeps its value until the next result load.
- **Abort:** ce_i = 0 in BUSY → IDLE on the next edge. result_o is not updated. A new ce_i = 1 then starts a fresh operation from IDLE.
- **Input changes:** changes on rs1_i, rs2_i or op_i while BUSY or DONE are ignored.
- **Back-to-back operations:** ce_i must drop for at least one edge so the block passes through IDLE. Holding ce_i high in DONE never restarts.
- **Invalid state encoding (11):** → IDLE on the next edge.

## Timing
- **Reset (rst_i = 0, asynchronous):** state IDLE, cnt 0, all datapath registers 0.
  - result_o = 0 and status_o = 00.
  - ready_o = ~ce_i.
- **ready_o:** equals (state == DONE) || (state == IDLE && ce_i == 0).
  - It falls combinationally in the same cycle ce_i rises in IDLE.
- **Normal latency:** edge 1 captures operands and enters BUSY; edges 2–33 perform the 32 steps.
  - ready_o = 1 and result_o valid after edge 33, i.e. 33 cycles from the first edge with ce_i high.
- **Fast-path latency (divide-by-zero, overflow):** ready_o = 1 and result_o valid after edge 1.
- **Reset mid-operation:** immediate return to IDLE; result_o = 0 with no clock needed.
  - ce_i high at reset release starts a new operation on the first edge after release.
- **Result read:** the consumer samples result_o on the first edge where ce_i = 1 and ready_o = 1. It may drop ce_i on that same edge.

## Test plan
- **Signed DIV:** DIV rs1 = 0xFFFFFFF9 (−7), rs2 = 2, ce_i held → ready_o low for 33 cycles, then result_o = 0xFFFFFFFD (−3), status_o = 10.
- **Signed REM:** REM −7 / 2 → 0xFFFFFFFF (−1). REMU 0xFFFFFFF9 / 2 → 1. DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC. All after 33 cycles.
- **Divide by zero:** rs2 = 0 with rs1 = 0x12345678 → DIV/DIVU = 0xFFFFFFFF and REM/REMU = 0x12345678, ready_o high after 1 edge.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0. Ready after 1 edge.
- **Abort and input changes:**
  - Start DIVU 100 / 7, drop ce_i at cycle 10 → IDLE next edge and result_o unchanged.
  - Restart with 100 / 7 → result_o = 14 after 33 cycles.
  - Toggling rs1_i mid-operation has no effect on the result.
- **Reset:** assert rst_i low mid-BUSY without a clock → status_o = 00 and result_o = 0 immediately. ready_o follows ~ce_i.
